iterative_shifter: RTL and testbench
====================================

ITERATIVE_SHIFTER -- requirements
Module: iterative_shifter

Interface
REQ-001 SHALL have parameter W, default 8: data width in bits, W >= 2.
REQ-002 SHALL have parameter STEP, default 1: maximum bit positions shifted per cycle, 1 <= STEP <= W.
REQ-003 SHALL have localparam AW = $clog2(W): width of the shift amount.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  block can accept a request.
REQ-008 in_data  input  W  operand, unsigned bit vector.
REQ-009 in_amt  input  AW  shift amount, 0..W-1.
REQ-010 in_mode  input  2  00 logical left, 01 logical right, 10 arithmetic right, 11 rotate right.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 out_data  output  W  shifted result.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-015 in_ready SHALL equal (state == IDLE), registered state only, no combinational path from in_valid.
REQ-016 Accept SHALL occur on a rising edge with in_valid && in_ready; in_data, in_amt, in_mode are captured, and input changes afterwards have no effect.
REQ-017 On accept with in_amt == 0: next state DONE, out_data = in_data.
REQ-018 On accept with in_amt > 0: next state SHIFT, remaining count = in_amt.
REQ-019 In SHIFT, each edge SHALL shift the working register by k = min(STEP, remaining) in the captured mode and decrement remaining by k; on the edge where remaining reaches 0 the next state SHALL be DONE.
REQ-020 Latency: out_valid SHALL rise 1 cycle after accept for amt 0, else 1 + ceil(amt/STEP) cycles after accept.
REQ-021 Logical shifts SHALL fill vacated bits with 0; arithmetic right SHALL fill with captured in_data[W-1]; rotate right SHALL wrap bit 0 into bit W-1.
REQ-022 out_valid SHALL equal (state == DONE); out_data SHALL be held stable while out_valid && !out_ready.
REQ-023 DONE with out_ready high SHALL return to IDLE on that edge; no new accept in that same cycle.
REQ-024 out_data SHALL reflect the working register in all states; it is meaningful only when out_valid is high.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, remaining 0, working register 0: in_ready 1, out_valid 0, out_data 0.
REQ-026 Reset asserted during SHIFT or DONE SHALL discard the operation; no result is produced after rst_n rises.
REQ-027 First accept after reset SHALL be possible on the first rising edge with rst_n high.

Configuration
REQ-028 Macro ITERATIVE_SHIFTER_ROTATE_EN SHALL control rotation support.
REQ-029 With ITERATIVE_SHIFTER_ROTATE_EN defined: mode 11 rotates right per REQ-021.
REQ-030 Without it: mode 11 SHALL behave exactly as mode 01 (logical right) and no rotate wrap logic is synthesised.

Verification (W=8 unless stated; in_data = 8'hB6)
REQ-031 STEP=1, amt=3, mode 00 -> out_data 8'hB0, out_valid 4 cycles after accept, in_ready low in between.
REQ-032 STEP=1, amt=3, modes 01/10/11 -> 8'h16 / 8'hF6 / 8'hD6 (11 with ROTATE_EN); 8'h16 for mode 11 without ROTATE_EN.
REQ-033 STEP=3, amt=7, mode 01 -> out_data 8'h01, out_valid 4 cycles after accept (steps 3,3,1).
REQ-034 amt=0, any mode -> out_data 8'hB6, out_valid 1 cycle after accept.
REQ-035 out_ready held low 5 cycles in DONE -> out_valid and out_data stable throughout; IDLE one edge after out_ready rises; in_data changes during SHIFT ignored.
REQ-036 rst_n pulsed low mid-SHIFT -> outputs asynchronously 0 / in_ready 1, no out_valid after release; next request completes normally.

Source files
------------

// File: rtl/iterative_shifter.sv
// Multi-cycle barrel shifter: shifts by up to STEP positions per clock until the requested amount is reached.
// Define ITERATIVE_SHIFTER_ROTATE_EN to enable rotate-right on mode 2'b11 (otherwise it acts as logical right).
module iterative_shifter #(
    parameter int W    = 8,
    parameter int STEP = 1,
    localparam int AW  = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic [AW-1:0] in_amt,
    input  logic [1:0]    in_mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [AW:0] STEP_W = (AW+1)'(STEP);

    state_t        state_q, state_d;
    logic [AW-1:0] rem_q, rem_d;
    logic [W-1:0]  work_q, work_d;
    logic [1:0]    mode_q, mode_d;
    logic [AW-1:0] step_k;
    logic [W-1:0]  shifted;

    // Final step may be shorter than STEP; STEP itself may exceed the AW-bit range.
    always_comb begin
        step_k = ({1'b0, rem_q} < STEP_W) ? rem_q : STEP_W[AW-1:0];
    end

`ifdef ITERATIVE_SHIFTER_ROTATE_EN
    logic [AW:0] rot_left;
    always_comb begin
        rot_left = (AW+1)'(W) - {1'b0, step_k};
    end
`endif

    always_comb begin
        shifted = work_q >> step_k;
        case (mode_q)
            2'b00:   shifted = work_q << step_k;
            2'b10:   shifted = $signed(work_q) >>> step_k;
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
            2'b11:   shifted = (work_q >> step_k) | (work_q << rot_left);
`endif
            default: shifted = work_q >> step_k;
        endcase
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        work_d  = work_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = in_data;
                    mode_d  = in_mode;
                    rem_d   = in_amt;
                    state_d = (in_amt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                work_d = shifted;
                rem_d  = rem_q - step_k;
                if (rem_q == step_k) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            work_q  <= '0;
            mode_q  <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            work_q  <= work_d;
            mode_q  <= mode_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = work_q;

endmodule

// File: tb/tb_iterative_shifter.sv
// Bench for iterative_shifter: lane 0 uses STEP=1, lane 1 uses STEP=3, both fed the same requests
// and checked every cycle against a whole-shift reference model plus literal expectations.
module tb_iterative_shifter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic [2:0] in_amt;
    logic [1:0] in_mode;
    logic       out_ready;

    logic       in_ready_w [2];
    logic       out_valid_w[2];
    logic [7:0] out_data_w [2];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        iterative_shifter #(.W(8), .STEP(gi == 0 ? 1 : 3)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid),
            .in_ready (in_ready_w[gi]),
            .in_data  (in_data),
            .in_amt   (in_amt),
            .in_mode  (in_mode),
            .out_valid(out_valid_w[gi]),
            .out_ready(out_ready),
            .out_data (out_data_w[gi])
        );
    end

`ifdef ITERATIVE_SHIFTER_ROTATE_EN
    localparam logic [7:0] MODE3_B6_3 = 8'hD6;
    localparam logic [7:0] MODE3_3C_4 = 8'hC3;
`else
    localparam logic [7:0] MODE3_B6_3 = 8'h16;
    localparam logic [7:0] MODE3_3C_4 = 8'h03;
`endif

    function automatic int lane_step(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // Whole-shift result computed in one go from the shift rules.
    function automatic logic [7:0] ref_shift(input logic [7:0] d, input int amt, input logic [1:0] mode);
        logic [15:0] dd;
        case (mode)
            2'b00:   return d << amt;
            2'b01:   return d >> amt;
            2'b10:   return $signed(d) >>> amt;
            default: begin
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
                dd = {d, d} >> amt;
                return dd[7:0];
`else
                dd = {8'h00, d} >> amt;
                return dd[7:0];
`endif
            end
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: 0 = waiting for a request, 1 = busy (cycles left in cnt), 2 = result held.
    int         m_phase[2];
    int         m_cnt  [2];
    logic [7:0] m_data [2];

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_phase[i] <= 0;
                m_cnt[i]   <= 0;
                m_data[i]  <= 8'h00;
            end else begin
                case (m_phase[i])
                    0: if (in_valid) begin
                        m_data[i] <= ref_shift(in_data, int'(in_amt), in_mode);
                        if (in_amt == 3'd0) begin
                            m_phase[i] <= 2;
                        end else begin
                            m_phase[i] <= 1;
                            m_cnt[i]   <= (int'(in_amt) + lane_step(i) - 1) / lane_step(i);
                        end
                    end
                    1: begin
                        m_cnt[i] <= m_cnt[i] - 1;
                        if (m_cnt[i] == 1) m_phase[i] <= 2;
                    end
                    default: if (out_ready) m_phase[i] <= 0;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("in_ready lane%0d", i), int'(in_ready_w[i]), int'(m_phase[i] == 0));
                check($sformatf("out_valid lane%0d", i), int'(out_valid_w[i]), int'(m_phase[i] == 2));
                if (m_phase[i] == 2)
                    check($sformatf("out_data lane%0d", i), int'(out_data_w[i]), int'(m_data[i]));
            end
        end
    end

    task automatic wait_idle();
        int n;
        for (n = 0; n < 40; n++) begin
            @(negedge clk);
            if (in_ready_w[0] && in_ready_w[1]) break;
        end
        check("wait_idle", n, (n < 40) ? n : -1);
    endtask

    task automatic run_req(input logic [7:0] d, input logic [2:0] amt, input logic [1:0] mode,
                           input logic [7:0] e0, input logic [7:0] e1,
                           input int l0, input int l1, input int hold);
        int         lat[2];
        logic [7:0] got[2];
        wait_idle();
        in_valid  = 1'b1;
        in_data   = d;
        in_amt    = amt;
        in_mode   = mode;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = ~d;
        in_amt   = ~amt;
        in_mode  = ~mode;
        lat = '{0, 0};
        got = '{8'h00, 8'h00};
        for (int n = 1; n <= 40; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (lat[i] == 0 && out_valid_w[i]) begin
                    lat[i] = n;
                    got[i] = out_data_w[i];
                end
            end
            if (lat[0] != 0 && lat[1] != 0) break;
            @(negedge clk);
        end
        check("latency lane0", lat[0], l0);
        check("latency lane1", lat[1], l1);
        check("result lane0", int'(got[0]), int'(e0));
        check("result lane1", int'(got[1]), int'(e1));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                check("held valid", int'(out_valid_w[i]), 1);
                check("held data", int'(out_data_w[i]), int'(got[i]));
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("back to idle ready", int'(in_ready_w[i]), 1);
            check("back to idle valid", int'(out_valid_w[i]), 0);
        end
        $display("[TB] req data=%h amt=%0d mode=%0d -> lane0 %h (lat %0d) lane1 %h (lat %0d)",
                 d, amt, mode, got[0], lat[0], got[1], lat[1]);
    endtask

    initial begin
        int seen_valid[2];
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_amt    = 3'd0;
        in_mode   = 2'b00;
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #2;
        for (int i = 0; i < 2; i++) begin
            check("reset in_ready", int'(in_ready_w[i]), 1);
            check("reset out_valid", int'(out_valid_w[i]), 0);
            check("reset out_data", int'(out_data_w[i]), 0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_req(8'hB6, 3'd3, 2'b00, 8'hB0, 8'hB0, 4, 2, 0);
        run_req(8'hB6, 3'd3, 2'b01, 8'h16, 8'h16, 4, 2, 0);
        run_req(8'hB6, 3'd3, 2'b10, 8'hF6, 8'hF6, 4, 2, 0);
        run_req(8'hB6, 3'd3, 2'b11, MODE3_B6_3, MODE3_B6_3, 4, 2, 0);
        run_req(8'hB6, 3'd7, 2'b01, 8'h01, 8'h01, 8, 4, 0);
        run_req(8'hB6, 3'd0, 2'b00, 8'hB6, 8'hB6, 1, 1, 0);
        run_req(8'hB6, 3'd0, 2'b11, 8'hB6, 8'hB6, 1, 1, 0);
        run_req(8'hB6, 3'd7, 2'b10, 8'hFF, 8'hFF, 8, 4, 5);
        run_req(8'h5A, 3'd5, 2'b00, 8'h40, 8'h40, 6, 3, 0);
        run_req(8'h3C, 3'd4, 2'b11, MODE3_3C_4, MODE3_3C_4, 5, 3, 0);
        run_req(8'h76, 3'd2, 2'b10, 8'h1D, 8'h1D, 3, 2, 0);

        // Reset in the middle of a long shift must abandon it.
        wait_idle();
        in_valid = 1'b1;
        in_data  = 8'hB6;
        in_amt   = 3'd7;
        in_mode  = 2'b00;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("midshift reset in_ready", int'(in_ready_w[i]), 1);
            check("midshift reset out_valid", int'(out_valid_w[i]), 0);
            check("midshift reset out_data", int'(out_data_w[i]), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = '{0, 0};
        repeat (12) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++)
                if (out_valid_w[i]) seen_valid[i] = 1;
        end
        check("no result after reset lane0", seen_valid[0], 0);
        check("no result after reset lane1", seen_valid[1], 0);
        $display("[TB] reset mid-shift: results discarded");

        run_req(8'hB6, 3'd3, 2'b01, 8'h16, 8'h16, 4, 2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
